// File: rtl/hwpe_stream_earlystall_source_if.sv
// Stream interface carrying valid/ready handshake, data and byte strobes.
// Source drives valid/data/strb; sink drives ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_earlystall_source.sv
// Strided memory reader feeding an early-stall stream sink (LATENCY in 1..2).
// Optional slack checker enabled by HWPE_STREAM_EARLYSTALL_SRC_CHECK_EN.
module hwpe_stream_earlystall_source #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    hwpe_stream_intf_stream.source push_o,
    output logic                  overflow_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  issued_q;
    logic [LATENCY-1:0]    vld_q, vld_d;
    logic                  done_q, done_d;
    logic                  req;
    logic                  accept;
    logic [LATENCY-1:0]    vld_older;

    // All in-flight slots except the one presenting this cycle; zero means
    // the register will be empty after this edge.
    assign vld_older = vld_q << 1;
    assign accept    = (state_q == IDLE) && start_i && (len_i != '0);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) state_d = RUN;
                    else             done_d  = 1'b1;
                end
            end
            RUN: begin
                if (push_o.ready && (issued_q < len_q)) begin
                    req = 1'b1;
                    if (issued_q == len_q - CNT_WIDTH'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (vld_older == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        vld_d = vld_older | LATENCY'(req);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            issued_q <= '0;
            vld_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            if (accept) begin
                addr_q   <= base_addr_i;
                stride_q <= stride_i;
                len_q    <= len_i;
                issued_q <= '0;
            end else if (req) begin
                addr_q   <= addr_q + stride_q;
                issued_q <= issued_q + CNT_WIDTH'(1);
            end
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign mem_req_o   = req;
    assign mem_addr_o  = req ? addr_q : '0;

    assign push_o.valid = vld_q[LATENCY-1];
    assign push_o.data  = push_o.valid ? mem_rdata_i : '0;
    assign push_o.strb  = push_o.valid ? '1 : '0;

`ifdef HWPE_STREAM_EARLYSTALL_SRC_CHECK_EN
    logic [1:0] stall_q;
    logic       ovf_q;

    // Third consecutive valid-without-ready cycle exceeds the sink's slack.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            stall_q <= '0;
            ovf_q   <= 1'b0;
        end else if (push_o.valid && !push_o.ready) begin
            if (stall_q == 2'd2) ovf_q   <= 1'b1;
            else                 stall_q <= stall_q + 2'd1;
        end else begin
            stall_q <= '0;
        end
    end

    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

endmodule
